// File: rtl/nv_cdc_hs_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : nv_cdc_hs_pkg
//  Purpose  : Shared types and constants for the toggle req/ack CDC source:
//             FSM state encoding, parameter defaults and legal ranges.
//  Revision : 1.0  initial release
// ============================================================================
package nv_cdc_hs_pkg;

  // Source FSM: idle (can accept) or waiting for the ack toggle to return
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } hs_state_t;

  localparam int unsigned C_SYNC_STAGES_DEF = 3;
  localparam int unsigned C_TIMEOUT_CYC_DEF = 1023;
  localparam int unsigned C_TIMEOUT_W_DEF   = 16;

  localparam int unsigned C_SYNC_STAGES_MIN = 2;
  localparam int unsigned C_SYNC_STAGES_MAX = 4;

endpackage : nv_cdc_hs_pkg
`default_nettype wire

// File: rtl/nv_sync_rstn.sv
`default_nettype none
// ============================================================================
//  Module   : nv_sync_rstn
//  Purpose  : Single-bit multi-flop level synchronizer, async active-low
//             reset to 0.
//  Ports    : clk   - destination clock
//             rstn  - asynchronous active-low reset
//             i_d   - asynchronous input level
//             o_q   - synchronized level (STAGES clk edges of latency)
//  Revision : 1.0  initial release
// ============================================================================
module nv_sync_rstn #(
  parameter int unsigned STAGES = 3
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule : nv_sync_rstn
`default_nettype wire

// File: rtl/nv_cdc_hs_src.sv
`default_nettype none
// ============================================================================
//  Module   : nv_cdc_hs_src
//  Purpose  : Transmit end of a toggle-based req/ack bus handshake. Accepts
//             one word on valid/ready, toggles xfer_req and holds xfer_data
//             until the synchronized xfer_ack toggle matches the request.
//  Ports    : clk, rstn                     - clock, async active-low reset
//             src_valid/src_ready/src_data  - source word interface
//             xfer_req/xfer_data            - toggle request + held payload
//             xfer_ack                      - ack toggle (async to clk)
//             busy                          - transfer in flight
//             timeout_err/proto_err/err_clr - sticky error flags + clear
//  Revision : 1.0  initial release
// ============================================================================
module nv_cdc_hs_src
  import nv_cdc_hs_pkg::*;
#(
  parameter int unsigned DW          = 32,
  parameter int unsigned SYNC_STAGES = C_SYNC_STAGES_DEF,
  parameter int unsigned TIMEOUT_CYC = C_TIMEOUT_CYC_DEF,
  parameter int unsigned TIMEOUT_W   = C_TIMEOUT_W_DEF
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          src_valid,
  output logic          src_ready,
  input  logic [DW-1:0] src_data,
  output logic          xfer_req,
  output logic [DW-1:0] xfer_data,
  input  logic          xfer_ack,
  output logic          busy,
  output logic          timeout_err,
  output logic          proto_err,
  input  logic          err_clr
);

  // Elaboration-time parameter checks
  if ((SYNC_STAGES < C_SYNC_STAGES_MIN) || (SYNC_STAGES > C_SYNC_STAGES_MAX)) begin : g_bad_sync
    $error("nv_cdc_hs_src: SYNC_STAGES out of range 2..4");
  end
  if (TIMEOUT_CYC >= (64'd1 << TIMEOUT_W)) begin : g_bad_timeout
    $error("nv_cdc_hs_src: TIMEOUT_CYC does not fit in TIMEOUT_W bits");
  end

  hs_state_t            r_state;
  logic                 r_req;
  logic [DW-1:0]        r_data;
  logic [TIMEOUT_W-1:0] r_cnt;
  logic                 r_to_err;
  logic                 r_proto_err;

  logic                 w_ack_s;
  logic                 w_ready;
  logic                 w_cnt_sat;
  logic [TIMEOUT_W-1:0] w_cnt_inc;
  logic                 w_to_hit;
  logic                 w_proto_hit;

  nv_sync_rstn #(
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk  (clk),
    .rstn (rstn),
    .i_d  (xfer_ack),
    .o_q  (w_ack_s)
  );

  // Ready only when idle and the ack phase has caught up with req; a stray
  // ack toggle therefore also blocks new words until the phases re-align.
  assign w_ready     = (r_state == ST_IDLE) && (w_ack_s == r_req);
  assign w_cnt_sat   = &r_cnt;
  assign w_cnt_inc   = r_cnt + TIMEOUT_W'(1);
  // Fires on the edge where the wait counter lands on TIMEOUT_CYC
  assign w_to_hit    = (TIMEOUT_CYC != 0) && (r_state == ST_WAIT) && !w_cnt_sat &&
                       (w_cnt_inc == TIMEOUT_W'(TIMEOUT_CYC));
  assign w_proto_hit = (r_state == ST_IDLE) && (w_ack_s != r_req);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= ST_IDLE;
      r_req       <= 1'b0;
      r_data      <= '0;
      r_cnt       <= '0;
      r_to_err    <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      if (r_state == ST_IDLE) begin
        if (src_valid && w_ready) begin
          r_data  <= src_data;
          r_req   <= ~r_req;
          r_cnt   <= '0;
          r_state <= ST_WAIT;
        end
      end else begin
        if (!w_cnt_sat) begin
          r_cnt <= w_cnt_inc;
        end
        if (w_ack_s == r_req) begin
          r_state <= ST_IDLE;
        end
      end

      // Sticky flags: a set on the same edge as err_clr wins
      if (w_to_hit) begin
        r_to_err <= 1'b1;
      end else if (err_clr) begin
        r_to_err <= 1'b0;
      end

      if (w_proto_hit) begin
        r_proto_err <= 1'b1;
      end else if (err_clr) begin
        r_proto_err <= 1'b0;
      end
    end
  end

  assign src_ready   = w_ready;
  assign busy        = (r_state == ST_WAIT);
  assign xfer_req    = r_req;
  assign xfer_data   = r_data;
  assign timeout_err = r_to_err;
  assign proto_err   = r_proto_err;

endmodule : nv_cdc_hs_src
`default_nettype wire
